fifo_stream_reader: RTL and testbench

- Read-side master for the team's sync FIFO: drives the FIFO's rd_en, captures data_out and presents it as a valid/ready stream.
- Groups beats into fixed-length bursts, flags the last beat of each burst and counts completed bursts.
- Sits between the sync FIFO and any downstream consumer that can apply backpressure.
- A 3-entry internal buffer gives full throughput with no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_stream_reader.sv | 123 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO. It pulls words into a 3-entry buffer
// and presents them as a valid/ready stream, framed into fixed-length bursts.
module fifo_stream_reader #(
  parameter int DATAWIDTH = 8,
  parameter int BURST_LEN = 4,
  parameter int BEATWIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATAWIDTH-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [15:0]          frame_cnt,
  output logic                 idle
);

  localparam logic [BEATWIDTH-1:0] LAST_BEAT = BEATWIDTH'(BURST_LEN - 1);

  logic [1:0]           occ_q, occ_d;
  logic [1:0]           head_q, head_d;
  logic [1:0]           tail_q, tail_d;
  logic                 inflight_q, inflight_d;
  logic [BEATWIDTH-1:0] beat_q, beat_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [DATAWIDTH-1:0] buf_q [3];
  logic [DATAWIDTH-1:0] buf_d [3];

  logic push;
  logic pop;
  logic credit_ok;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are credited against buffered plus in-flight words, so the buffer
  // can absorb every outstanding read without ever looking at m_ready.
  always_comb begin
    credit_ok  = (3'(occ_q) + 3'(inflight_q)) < 3'd3;
    fifo_rd_en = !rst && en && !fifo_empty && credit_ok;
  end

  always_comb begin
    m_valid = (occ_q != 2'd0);
    case (head_q)
      2'd1:    m_data = buf_q[1];
      2'd2:    m_data = buf_q[2];
      default: m_data = buf_q[0];
    endcase
    m_last    = m_valid && (beat_q == LAST_BEAT);
    frame_cnt = frame_cnt_q;
    idle      = (occ_q == 2'd0) && !inflight_q;
  end

  always_comb begin
    push       = inflight_q;
    pop        = m_valid && m_ready;
    inflight_d = fifo_rd_en && !fifo_empty;

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;

    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      if (m_last) begin
        beat_d      = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= 2'd0;
      head_q      <= 2'd0;
      tail_q      <= 2'd0;
      inflight_q  <= 1'b0;
      beat_q      <= '0;
      frame_cnt_q <= 16'd0;
    end else begin
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      inflight_q  <= inflight_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Each buffer slot captures fifo_data only when the tail points at it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_buf
    always_comb begin
      buf_d[gi] = buf_q[gi];
      if (push && (tail_q == 2'(gi))) begin
        buf_d[gi] = fifo_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        buf_q[gi] <= '0;
      end else begin
        buf_q[gi] <= buf_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-based
// model of the FIFO and of the words it owes downstream.
module tb_fifo_stream_reader;

  localparam int BL = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [15:0] frame_cnt;
  logic       idle;

  fifo_stream_reader #(.DATAWIDTH(8), .BURST_LEN(BL), .BEATWIDTH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_cnt(frame_cnt), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fq [$];     // contents of the external FIFO
  logic [7:0] exp_q [$];  // words read from the FIFO and not yet delivered
  int  beats, frames, xfers, accepts, cyc;
  int  tests, fails;
  bit  inflight_m, acc, xf, hold_m;
  logic [7:0] hold_data;
  int  first_acc_cyc, first_xf_cyc, last_xf_cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already set after a falling edge.
  task automatic cycle();
    bit exp_valid;
    fifo_empty = (fq.size() == 0);
    #1;
    exp_valid = (exp_q.size() - int'(inflight_m)) > 0;
    check_eq("fifo_rd_en", fifo_rd_en, !rst && en && !fifo_empty && (exp_q.size() < 3));
    check_eq("m_valid", m_valid, exp_valid);
    check_eq("idle", idle, exp_q.size() == 0);
    check_eq("frame_cnt", frame_cnt, frames);
    check_eq("m_last", m_last, exp_valid && ((beats % BL) == BL - 1));
    check_eq("credit", exp_q.size() <= 3, 1);
    if (exp_valid) check_eq("m_data", m_data, exp_q[0]);
    if (hold_m) check_eq("hold_data", m_data, hold_data);
    acc = fifo_rd_en && !fifo_empty;
    xf  = m_valid && m_ready;
    if (xf && !rst) begin
      $display("[TB] beat data=0x%02h last=%0d frame_cnt=%0d", m_data, m_last, frame_cnt);
      if (first_xf_cyc < 0) first_xf_cyc = cyc;
      last_xf_cyc = cyc;
    end
    if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
    hold_m    = m_valid && !m_ready && !rst;
    hold_data = m_data;
    @(posedge clk);
    #1;
    if (acc) fifo_data = fq.pop_front();
    if (rst) begin
      exp_q.delete();
      beats = 0;
      frames = 0;
      inflight_m = 1'b0;
    end else begin
      if (xf && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if ((beats % BL) == BL - 1) frames = (frames + 1) % 65536;
        beats++;
        xfers++;
      end
      if (acc) begin
        exp_q.push_back(fifo_data);
        accepts++;
      end
      inflight_m = acc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
  endtask

  initial begin
    int x0, a0;
    rst = 1'b1; en = 1'b1; m_ready = 1'b0; fifo_data = 8'h00; fifo_empty = 1'b1;
    tests = 0; fails = 0; beats = 0; frames = 0; xfers = 0; accepts = 0; cyc = 0;
    inflight_m = 0; hold_m = 0; hold_data = 0;
    first_acc_cyc = -1; first_xf_cyc = -1; last_xf_cyc = -1;

    // 1: reset with a non-empty FIFO
    load(8, 8'h01);
    fifo_empty = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    cycle();
    check_eq("rst_m_data", m_data, 8'h00);
    rst = 1'b0;
    m_ready = 1'b1;
    a0 = cyc;

    // 2: streaming 8 words, bursts of 4
    for (int i = 0; i < 40 && !(xfers == 8 && idle); i++) cycle();
    check_eq("t1_first_rd", first_acc_cyc, a0);
    check_eq("t2_first_beat", first_xf_cyc, first_acc_cyc + 2);
    check_eq("t2_last_beat", last_xf_cyc, first_xf_cyc + 7);
    check_eq("t2_xfers", xfers, 8);
    check_eq("t2_frames", frame_cnt, 16'd2);
    check_eq("t2_idle", idle, 1'b1);

    // 3: backpressure fills the buffer
    m_ready = 1'b0;
    load(5, 8'h01);
    a0 = accepts;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("t3_accepts", accepts - a0, 3);
    check_eq("t3_fifo_left", fq.size(), 2);
    check_eq("t3_head", m_data, 8'h01);
    m_ready = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 30 && !(xfers - x0 == 5 && idle); i++) cycle();
    check_eq("t3_xfers", xfers - x0, 5);

    // 4: alternating ready
    load(8, 8'h21);
    x0 = xfers;
    for (int i = 0; i < 60 && !(xfers - x0 == 8 && idle); i++) begin
      m_ready = i[0];
      cycle();
    end
    check_eq("t4_xfers", xfers - x0, 8);

    // 5: en dropped after two accepted reads
    m_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    load(6, 8'h01);
    a0 = accepts;
    x0 = xfers;
    for (int i = 0; i < 10 && accepts - a0 < 2; i++) cycle();
    en = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check_eq("t5_hold_xfers", xfers - x0, 2);
    check_eq("t5_hold_fifo", fq.size(), 4);
    check_eq("t5_hold_valid", m_valid, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 30 && !(xfers - x0 == 6 && idle); i++) cycle();
    check_eq("t5_xfers", xfers - x0, 6);
    check_eq("t5_frames", frame_cnt, 16'd1);

    // 6: reset with two words buffered mid-burst
    load(4, 8'h41);
    x0 = xfers;
    for (int i = 0; i < 20 && xfers - x0 < 2; i++) cycle();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    check_eq("t6_valid", m_valid, 1'b0);
    check_eq("t6_frames", frame_cnt, 16'd0);
    load(4, 8'h51);
    x0 = xfers;
    for (int i = 0; i < 30 && !(xfers - x0 == 4 && idle); i++) cycle();
    check_eq("t6_xfers", xfers - x0, 4);
    check_eq("t6_frames_end", frame_cnt, 16'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 16) fq.push_back(8'($urandom));
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 60; i++) cycle();
    check_eq("rand_idle", idle, 1'b1);
    check_eq("rand_fifo_drained", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
